// File: rtl/binis_pkg.sv
// rtl/binis_pkg.sv - shared types, default sizes and helpers for the boarding-gate sequencer
package binis_pkg;

    // Gate sequencer states: idle, sending passengers, waiting for verdict, reporting
    typedef enum logic [1:0] {
        BOS    = 2'd0,
        GONDER = 2'd1,
        BEKLE  = 2'd2,
        SONUC  = 2'd3
    } durum_t;

    // One passenger record as queued by the host
    typedef struct packed {
        logic bilet;
        logic kimlik;
    } yolcu_t;

    localparam int VARSAYILAN_DERINLIK    = 8;
    localparam int VARSAYILAN_ZAMAN_ASIMI = 64;

    // Passenger counter increment that sticks at 255
    function automatic logic [7:0] doygun_artir(input logic [7:0] deger);
        return (deger == 8'hff) ? deger : deger + 8'd1;
    endfunction

endpackage

// File: rtl/yolcu_fifo.sv
// rtl/yolcu_fifo.sv - synchronous passenger-record FIFO with wrap-bit full/empty flags
module yolcu_fifo
    import binis_pkg::*;
#(
    parameter int DERINLIK = VARSAYILAN_DERINLIK
)
(
    input  logic   saat,
    input  logic   reset,
    input  logic   yaz,
    input  yolcu_t yaz_veri,
    input  logic   oku,
    output yolcu_t oku_veri,
    output logic   dolu,
    output logic   bos
);

    localparam int AW = $clog2(DERINLIK);

    if (DERINLIK < 2 || (DERINLIK & (DERINLIK - 1)) != 0) begin : g_derinlik_hatasi
        $error("yolcu_fifo: DERINLIK must be a power of two and at least 2");
    end

    logic [AW:0] yaz_ptr;
    logic [AW:0] oku_ptr;
    yolcu_t      bellek [DERINLIK];
    logic        yaz_ok;
    logic        oku_ok;

    // A write into a full FIFO is only safe when a pop frees the slot in the same cycle
    assign oku_ok   = oku && !bos;
    assign yaz_ok   = yaz && (!dolu || oku_ok);
    assign bos      = (yaz_ptr == oku_ptr);
    assign dolu     = (yaz_ptr[AW] != oku_ptr[AW]) && (yaz_ptr[AW-1:0] == oku_ptr[AW-1:0]);
    assign oku_veri = bellek[oku_ptr[AW-1:0]];

    // Pointer update; clearing both pointers empties the FIFO
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            yaz_ptr <= '0;
            oku_ptr <= '0;
        end else begin
            if (yaz_ok) begin
                yaz_ptr <= yaz_ptr + (AW + 1)'(1);
            end
            if (oku_ok) begin
                oku_ptr <= oku_ptr + (AW + 1)'(1);
            end
        end
    end

    // Record storage; contents are only meaningful between the pointers
    always_ff @(posedge saat) begin
        if (yaz_ok) begin
            bellek[yaz_ptr[AW-1:0]] <= yaz_veri;
        end
    end

endmodule

// File: rtl/binis_kapisi.sv
// rtl/binis_kapisi.sv - boarding-gate sequencer top; optional BEKLE timeout under ZAMAN_ASIMI_EN
module binis_kapisi
    import binis_pkg::*;
#(
    parameter int DERINLIK    = VARSAYILAN_DERINLIK,
    parameter int ZAMAN_ASIMI = VARSAYILAN_ZAMAN_ASIMI
)
(
    input  logic       saat,
    input  logic       reset,
    input  logic       yolcu_gecerli,
    output logic       yolcu_hazir,
    input  logic       yolcu_bilet,
    input  logic       yolcu_kimlik,
    input  logic       baslat,
    output logic       basla,
    output logic       o_yolcu,
    output logic       g_kimlik,
    input  logic       kalkis,
    input  logic       bitti,
    output logic       mesgul,
    output logic       sonuc_gecerli,
    output logic       sonuc_kalkis,
    output logic       sonuc_zaman_asimi,
    output logic [7:0] gonderilen
);

    if (ZAMAN_ASIMI < 1) begin : g_zaman_asimi_hatasi
        $error("binis_kapisi: ZAMAN_ASIMI must be at least 1");
    end

    durum_t durum;
    yolcu_t bas_kayit;
    yolcu_t gelen_kayit;
    logic   fifo_dolu;
    logic   fifo_bos;
    logic   pop;

`ifdef ZAMAN_ASIMI_EN
    localparam int SW = $clog2(ZAMAN_ASIMI + 1);
    localparam logic [SW-1:0] SAYAC_SON = SW'(ZAMAN_ASIMI - 1);
    logic [SW-1:0] sayac;
`endif

    // The session-start edge already pops the first passenger so it appears with basla
    assign pop = !fifo_bos && ((durum == BOS && baslat) || (durum == GONDER && !bitti));

    assign yolcu_hazir        = !fifo_dolu;
    assign gelen_kayit.bilet  = yolcu_bilet;
    assign gelen_kayit.kimlik = yolcu_kimlik;

    yolcu_fifo #(
        .DERINLIK (DERINLIK)
    ) u_fifo (
        .saat     (saat),
        .reset    (reset),
        .yaz      (yolcu_gecerli),
        .yaz_veri (gelen_kayit),
        .oku      (pop),
        .oku_veri (bas_kayit),
        .dolu     (fifo_dolu),
        .bos      (fifo_bos)
    );

    // Session FSM with all host- and controller-facing outputs registered
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            durum             <= BOS;
            basla             <= 1'b0;
            o_yolcu           <= 1'b0;
            g_kimlik          <= 1'b0;
            mesgul            <= 1'b0;
            sonuc_gecerli     <= 1'b0;
            sonuc_kalkis      <= 1'b0;
            sonuc_zaman_asimi <= 1'b0;
            gonderilen        <= 8'd0;
`ifdef ZAMAN_ASIMI_EN
            sayac             <= '0;
`endif
        end else begin
            sonuc_gecerli <= 1'b0;
            unique case (durum)
                BOS: begin
                    if (baslat && !fifo_bos) begin
                        durum      <= GONDER;
                        basla      <= 1'b1;
                        mesgul     <= 1'b1;
                        o_yolcu    <= bas_kayit.bilet;
                        g_kimlik   <= bas_kayit.kimlik;
                        gonderilen <= 8'd1;
                    end
                end
                GONDER: begin
                    if (bitti) begin
                        // Verdict arrives early; unsent records remain queued
                        durum             <= SONUC;
                        basla             <= 1'b0;
                        o_yolcu           <= 1'b0;
                        g_kimlik          <= 1'b0;
                        sonuc_gecerli     <= 1'b1;
                        sonuc_kalkis      <= kalkis;
                        sonuc_zaman_asimi <= 1'b0;
                    end else if (!fifo_bos) begin
                        o_yolcu    <= bas_kayit.bilet;
                        g_kimlik   <= bas_kayit.kimlik;
                        gonderilen <= doygun_artir(gonderilen);
                    end else begin
                        durum    <= BEKLE;
                        o_yolcu  <= 1'b0;
                        g_kimlik <= 1'b0;
`ifdef ZAMAN_ASIMI_EN
                        sayac    <= '0;
`endif
                    end
                end
                BEKLE: begin
                    if (bitti) begin
                        durum             <= SONUC;
                        basla             <= 1'b0;
                        sonuc_gecerli     <= 1'b1;
                        sonuc_kalkis      <= kalkis;
                        sonuc_zaman_asimi <= 1'b0;
`ifdef ZAMAN_ASIMI_EN
                    end else if (sayac == SAYAC_SON) begin
                        // Controller never answered; close the session as not departed
                        durum             <= SONUC;
                        basla             <= 1'b0;
                        sonuc_gecerli     <= 1'b1;
                        sonuc_kalkis      <= 1'b0;
                        sonuc_zaman_asimi <= 1'b1;
                    end else begin
                        sayac <= sayac + SW'(1);
`endif
                    end
                end
                SONUC: begin
                    durum  <= BOS;
                    mesgul <= 1'b0;
                end
                default: begin
                    durum  <= BOS;
                    basla  <= 1'b0;
                    mesgul <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_binis_kapisi.sv
// tb/tb_binis_kapisi.sv - directed and randomized bench for binis_kapisi against a queue model
module tb_binis_kapisi;

    localparam int DER = 8;
    localparam int ZA  = 64;

    logic       saat = 1'b0;
    logic       reset = 1'b1;
    logic       yolcu_gecerli = 1'b0;
    logic       yolcu_hazir;
    logic       yolcu_bilet = 1'b0;
    logic       yolcu_kimlik = 1'b0;
    logic       baslat = 1'b0;
    logic       basla;
    logic       o_yolcu;
    logic       g_kimlik;
    logic       kalkis = 1'b0;
    logic       bitti = 1'b0;
    logic       mesgul;
    logic       sonuc_gecerli;
    logic       sonuc_kalkis;
    logic       sonuc_zaman_asimi;
    logic [7:0] gonderilen;

    int errors = 0;
    int checks = 0;
    logic [1:0] mq[$];

    binis_kapisi #(
        .DERINLIK    (DER),
        .ZAMAN_ASIMI (ZA)
    ) dut (
        .saat              (saat),
        .reset             (reset),
        .yolcu_gecerli     (yolcu_gecerli),
        .yolcu_hazir       (yolcu_hazir),
        .yolcu_bilet       (yolcu_bilet),
        .yolcu_kimlik      (yolcu_kimlik),
        .baslat            (baslat),
        .basla             (basla),
        .o_yolcu           (o_yolcu),
        .g_kimlik          (g_kimlik),
        .kalkis            (kalkis),
        .bitti             (bitti),
        .mesgul            (mesgul),
        .sonuc_gecerli     (sonuc_gecerli),
        .sonuc_kalkis      (sonuc_kalkis),
        .sonuc_zaman_asimi (sonuc_zaman_asimi),
        .gonderilen        (gonderilen)
    );

    always #5 saat = ~saat;

    task automatic tick();
        @(posedge saat);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n);
        return (n > 255) ? 255 : n;
    endfunction

    task automatic idle_checks(input string tag);
        chk({tag, "_basla"}, basla, 0);
        chk({tag, "_o_yolcu"}, o_yolcu, 0);
        chk({tag, "_g_kimlik"}, g_kimlik, 0);
        chk({tag, "_mesgul"}, mesgul, 0);
        chk({tag, "_sonuc_gecerli"}, sonuc_gecerli, 0);
        chk({tag, "_sonuc_kalkis"}, sonuc_kalkis, 0);
        chk({tag, "_sonuc_zaman"}, sonuc_zaman_asimi, 0);
        chk({tag, "_gonderilen"}, gonderilen, 0);
        chk({tag, "_hazir"}, yolcu_hazir, 1);
    endtask

    task automatic push(input logic [1:0] rec);
        chk("push_hazir", yolcu_hazir, (mq.size() < DER) ? 1 : 0);
        yolcu_gecerli = 1'b1;
        {yolcu_bilet, yolcu_kimlik} = rec;
        tick();
        yolcu_gecerli = 1'b0;
        if (mq.size() < DER) mq.push_back(rec);
    endtask

    // Session with the gate-side controller answering at the d-th edge after start
    task automatic session(input int d, input logic kal, input int wr_pct);
        logic [1:0] cur;
        logic [1:0] rec;
        int  sent;
        bit  gonder;
        bit  son;
        bit  wr;
        bit  popped;
        bit  full_before;
        baslat = 1'b1;
        tick();
        baslat = 1'b0;
        cur = mq.pop_front();
        sent = 1;
        gonder = 1;
        for (int i = 1; i <= d; i++) begin
            chk("ses_basla", basla, 1);
            chk("ses_mesgul", mesgul, 1);
            chk("ses_yolcu", {o_yolcu, g_kimlik}, cur);
            chk("ses_gonderilen", gonderilen, sat(sent));
            chk("ses_hazir", yolcu_hazir, (mq.size() < DER) ? 1 : 0);
            chk("ses_sonuc_gecerli", sonuc_gecerli, 0);
            son = (i == d);
            wr = ($urandom_range(99) < wr_pct);
            rec = 2'($urandom);
            yolcu_gecerli = wr;
            {yolcu_bilet, yolcu_kimlik} = rec;
            bitti = son;
            kalkis = son ? kal : 1'($urandom);
            full_before = (mq.size() == DER);
            popped = 0;
            tick();
            if (!son && gonder) begin
                if (mq.size() != 0) begin
                    cur = mq.pop_front();
                    sent++;
                    popped = 1;
                end else begin
                    gonder = 0;
                    cur = 2'b00;
                end
            end
            if (wr && (!full_before || popped)) mq.push_back(rec);
        end
        yolcu_gecerli = 1'b0;
        bitti = 1'b0;
        kalkis = 1'b0;
        chk("sonuc_gecerli", sonuc_gecerli, 1);
        chk("sonuc_kalkis", sonuc_kalkis, kal);
        chk("sonuc_zaman", sonuc_zaman_asimi, 0);
        chk("sonuc_basla", basla, 0);
        chk("sonuc_mesgul", mesgul, 1);
        chk("sonuc_gonderilen", gonderilen, sat(sent));
        tick();
        chk("bos_gecerli", sonuc_gecerli, 0);
        chk("bos_mesgul", mesgul, 0);
        chk("bos_kalkis_tut", sonuc_kalkis, kal);
        chk("bos_gonderilen_tut", gonderilen, sat(sent));
        chk("bos_yolcu", {o_yolcu, g_kimlik}, 0);
    endtask

    initial begin
        int bad;
        tick();
        tick();
        idle_checks("reset_hold");
        reset = 1'b0;
        tick();
        idle_checks("reset_rel");

        // Accepted session: three full records, verdict at N+5
        for (int i = 0; i < 3; i++) push(2'b11);
        session(5, 1'b1, 0);

        // Asynchronous reset in the middle of GONDER with three records still queued
        for (int i = 0; i < 4; i++) push(2'($urandom));
        baslat = 1'b1;
        tick();
        baslat = 1'b0;
        chk("pre_reset_basla", basla, 1);
        #2 reset = 1'b1;
        #1 idle_checks("async_reset");
        #1 reset = 1'b0;
        mq.delete();
        tick();
        chk("post_reset_hazir", yolcu_hazir, 1);
        baslat = 1'b1;
        tick();
        baslat = 1'b0;
        chk("empty_baslat_basla", basla, 0);
        chk("empty_baslat_mesgul", mesgul, 0);

        // Early rejection after the first passenger, then drain the two leftovers
        push(2'b01);
        push(2'b11);
        push(2'b11);
        session(1, 1'b0, 0);
        session(5, 1'b1, 0);

        // bitti in BOS does nothing
        bitti = 1'b1;
        kalkis = 1'b1;
        tick();
        bitti = 1'b0;
        kalkis = 1'b0;
        chk("bos_bitti_gecerli", sonuc_gecerli, 0);
        chk("bos_bitti_mesgul", mesgul, 0);

        // Full FIFO: ninth write dropped, all eight sent
        for (int i = 0; i < DER + 1; i++) push(2'($urandom));
        session(DER + 2, 1'($urandom), 0);

        // Continuous writes keep GONDER busy long enough to saturate gonderilen
        push(2'($urandom));
        push(2'($urandom));
        session(300, 1'b1, 100);

        // Randomized sessions with writes during GONDER
        for (int s = 0; s < 6; s++) begin
            int k;
            k = $urandom_range(1, DER);
            for (int i = 0; i < k; i++) push(2'($urandom));
            session($urandom_range(1, k + 4), 1'($urandom), 30);
        end
        if (mq.size() != 0) session(mq.size() + 2, 1'b0, 0);

        // Single record, controller silent
        push(2'b10);
        baslat = 1'b1;
        tick();
        baslat = 1'b0;
        void'(mq.pop_front());
        bad = 0;
`ifdef ZAMAN_ASIMI_EN
        for (int t = 1; t <= ZA; t++) begin
            tick();
            if (sonuc_gecerli !== 1'b0 || mesgul !== 1'b1) bad++;
        end
        chk("timeout_early_cycles", bad, 0);
        tick();
        chk("timeout_gecerli", sonuc_gecerli, 1);
        chk("timeout_flag", sonuc_zaman_asimi, 1);
        chk("timeout_kalkis", sonuc_kalkis, 0);
        chk("timeout_gonderilen", gonderilen, 1);
        tick();
        chk("timeout_done_gecerli", sonuc_gecerli, 0);
        chk("timeout_done_mesgul", mesgul, 0);
`else
        for (int t = 1; t <= 200; t++) begin
            tick();
            if (mesgul !== 1'b1 || sonuc_gecerli !== 1'b0) bad++;
        end
        chk("wait_mesgul_cycles", bad, 0);
        bitti = 1'b1;
        kalkis = 1'b1;
        tick();
        bitti = 1'b0;
        kalkis = 1'b0;
        chk("wait_gecerli", sonuc_gecerli, 1);
        chk("wait_kalkis", sonuc_kalkis, 1);
        chk("wait_zaman", sonuc_zaman_asimi, 0);
        chk("wait_gonderilen", gonderilen, 1);
        tick();
        chk("wait_done_mesgul", mesgul, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/binis_kapisi.md
# binis_kapisi

Boarding-gate sequencer that drives the `ucak` boarding controller from the passenger side. It buffers passenger records (ticket/ID flags) in a small FIFO and opens a boarding session on request by asserting `basla`. It then presents one passenger per clock on `o_yolcu`/`g_kimlik`, waits for the controller's `bitti`, and reports the captured `kalkis` verdict to the host as a single-cycle result.

## Interface
- `DERINLIK`, 8: FIFO depth in passenger records; power of two, minimum 2.
- `ZAMAN_ASIMI`, 64: cycles allowed in BEKLE before the session is aborted; only used with `ZAMAN_ASIMI_EN`.
- `saat` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `yolcu_gecerli` input 1: host offers a passenger record this cycle.
- `yolcu_hazir` output 1: FIFO can accept a record; equals `!full`.
- `yolcu_bilet` input 1: record field, ticket valid; forwarded as `o_yolcu`.
- `yolcu_kimlik` input 1: record field, ID valid; forwarded as `g_kimlik`.
- `baslat` input 1: host request to open a session; sampled only in BOS.
- `basla` output 1: session active, to `ucak`.
- `o_yolcu` output 1: current passenger ticket flag, to `ucak`.
- `g_kimlik` output 1: current passenger ID flag, to `ucak`.
- `kalkis` input 1: takeoff verdict from `ucak`.
- `bitti` input 1: session finished, from `ucak`.
- `mesgul` output 1: FSM not in BOS.
- `sonuc_gecerli` output 1: one-cycle pulse; result fields below are valid.
- `sonuc_kalkis` output 1: captured `kalkis`; holds until the next result.
- `sonuc_zaman_asimi` output 1: last session ended by timeout; holds until the next result.
- `gonderilen` output 8: passengers sent in the current or last session; saturates at 255.

## Operation
- **FIFO write.** A write occurs when `yolcu_gecerli & yolcu_hazir`. Writes are legal in every state. A record written during GONDER is sent in the same session if it arrives before the FIFO drains.
- **FSM states:** BOS, GONDER, BEKLE, SONUC.
- **BOS.**
  - `basla`, `o_yolcu` and `g_kimlik` are all 0.
  - If `baslat` is high and the FIFO is non-empty: clear `gonderilen` and go to GONDER.
  - If `baslat` is high and the FIFO is empty: ignore it and change no outputs.
- **GONDER.**
  - `basla` = 1.
  - Each cycle with the FIFO non-empty: pop one record, register it onto `o_yolcu`/`g_kimlik`, and increment `gonderilen`.
  - FIFO empty → go to BEKLE.
  - `bitti` sampled high → go to SONUC immediately. Records not yet sent stay in the FIFO.
- **BEKLE.**
  - `basla` = 1; `o_yolcu` = `g_kimlik` = 0.
  - `bitti` high → go to SONUC.
- **SONUC.**
  - `basla` = 0.
  - `sonuc_kalkis` = `kalkis` sampled together with `bitti`.
  - `sonuc_zaman_asimi` = 0.
  - `sonuc_gecerli` = 1 for exactly one cycle, then go to BOS.
- **Simultaneous events.**
  - A FIFO write and a pop in the same cycle keep the count unchanged. A write is allowed while full only if a pop happens in that same cycle; `yolcu_hazir` still reads 0 then.
  - `bitti` wins over a pending pop.
- **Wrap-around.** FIFO pointers are log2(DERINLIK)+1 bits wide with a wrap bit: full = MSBs differ and LSBs equal; empty = pointers equal.
- **Reset.**
  - Asynchronous reset at any time, including mid-session: FSM returns to BOS and the FIFO is cleared.
  - Every output goes to 0 (`yolcu_hazir` = 1 after reset), and `gonderilen` is cleared.

## Timing
- `baslat` sampled at edge N → `basla` = 1 and the first passenger appear after edge N. Both are registered together.
- With k records in the FIFO and no writes: passengers occupy cycles N+1..N+k. BEKLE starts at N+k+1 and `o_yolcu` = `g_kimlik` = 0 from then.
- `bitti` sampled high at edge M → `basla` = 0 and `sonuc_gecerli` = 1 after M, and `mesgul` = 0 after M+1.
- `bitti` is ignored in BOS and SONUC.
- All outputs are registered; there are no combinational paths from inputs to outputs except `yolcu_hazir` (derived from FIFO state only).

## Configuration
- `ZAMAN_ASIMI_EN` defined:
  - A counter of width $clog2(ZAMAN_ASIMI+1) runs in BEKLE.
  - After ZAMAN_ASIMI cycles without `bitti`, go to SONUC with `sonuc_zaman_asimi` = 1 and `sonuc_kalkis` = 0.
  - The counter clears on entering BEKLE.
- `ZAMAN_ASIMI_EN` undefined: BEKLE waits indefinitely; `sonuc_zaman_asimi` is tied to 0.

## Structure
- Package `binis_pkg` holds:
  - the state enum `durum_t` (BOS, GONDER, BEKLE, SONUC);
  - the record struct `yolcu_t` {bilet, kimlik};
  - the default constants for DERINLIK and ZAMAN_ASIMI.
- Sub-module `yolcu_fifo`: a parameterised synchronous FIFO of `yolcu_t` with full/empty flags. The top level contains the FSM, counters and output registers.

## Test plan
- **Reset.** Reset pulse mid-GONDER with 3 records queued → all outputs 0, `yolcu_hazir` = 1, FIFO empty; then `baslat` = 1 is ignored.
- **Accepted session.** Push {1,1},{1,1},{1,1}, `baslat` at edge N; `ucak` model asserts `bitti` = 1, `kalkis` = 1 at N+5 →
  - `o_yolcu`/`g_kimlik` = 1 for cycles N+1..N+3 and 0 from N+4;
  - `sonuc_gecerli` pulses once with `sonuc_kalkis` = 1;
  - `gonderilen` = 3.
- **Early rejection.** Push {0,1},{1,1},{1,1}; model asserts `bitti` = 1, `kalkis` = 0 one cycle after the first passenger → SONUC with `sonuc_kalkis` = 0, `gonderilen` = 1, 2 records remain in the FIFO.
- **Full FIFO.** Write DERINLIK = 8 records → `yolcu_hazir` = 0 and a ninth write is dropped. Start a session → exactly 8 passengers are sent, and `yolcu_hazir` returns to 1 the cycle after the first pop.
- **Timeout, macro defined.** ZAMAN_ASIMI = 64, 1 record, `bitti` never asserted → `sonuc_gecerli` exactly 64 cycles after entering BEKLE, `sonuc_zaman_asimi` = 1, `sonuc_kalkis` = 0.
- **Timeout, macro undefined.** Same stimulus → `mesgul` stays 1 for 200 cycles, then `bitti` = 1 produces a normal result.
